// File: rtl/axi_pkg.sv
// AXI write-address channel payload and response/burst encodings.
package axi_pkg;

   localparam int unsigned AddrWidth = 64;

   typedef logic [1:0] resp_t;
   typedef logic [1:0] burst_t;

   localparam resp_t  RespOkay   = 2'b00;
   localparam resp_t  RespSlvErr = 2'b10;
   localparam burst_t BurstIncr  = 2'b01;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      burst_t               burst;
   } aw_chan_t;

endpackage

// File: rtl/vlsu_pkg.sv
// Shared VLSU types and constants for the sequential store path.
// Contents: bus geometry constants, store request, global meta record and
// per-beat transaction control payloads.
package vlsu_pkg;

   localparam int unsigned AxiDataWidth  = 64;
   localparam int unsigned AxiAddrWidth  = 64;
   localparam int unsigned VlWidth       = 16;
   localparam int unsigned BusBytes      = AxiDataWidth / 8;
   localparam int unsigned BusNibbles    = AxiDataWidth / 4;
   localparam int unsigned BeatBits      = $clog2(BusBytes);
   localparam int unsigned LbnWidth      = $clog2(BusNibbles) + 1;
   localparam int unsigned MaxBurstBeats = 256;
   localparam int unsigned BeatCntWidth  = $clog2(MaxBurstBeats) + 1;
   localparam int unsigned PageBytes     = 4096;
   localparam int unsigned PageBits      = $clog2(PageBytes);

   typedef struct packed {
      logic [AxiAddrWidth-1:0] addr;
      logic [VlWidth-1:0]      vl;
      logic [VlWidth-1:0]      vstart;
      logic [1:0]              sew;
   } store_req_t;

   typedef struct packed {
      logic [VlWidth-1:0] vstart;
      logic [1:0]         sew;
   } meta_glb_t;

   typedef struct packed {
      logic [AxiAddrWidth-1:0] addr;
      logic                    is_head;
      logic [7:0]              rmn_beat;
      logic [LbnWidth-1:0]     lb_n;
      logic                    is_final_txn;
   } seq_store_txn_ctrl_t;

endpackage

// File: rtl/seq_store_burst_calc.sv
// Combinational burst geometry for the next AXI write burst.
// Ports: cur_addr / end_addr (exclusive) in; burst_end (exclusive), beats,
// lb_n (nibbles valid in the last beat) and is_final out.
module seq_store_burst_calc
   import vlsu_pkg::*;
(
   input  logic [AxiAddrWidth-1:0] cur_addr,
   input  logic [AxiAddrWidth-1:0] end_addr,
   output logic [AxiAddrWidth-1:0] burst_end,
   output logic [BeatCntWidth-1:0] beats,
   output logic [LbnWidth-1:0]     lb_n,
   output logic                    is_final
);

   logic [AxiAddrWidth-1:0] aligned;
   logic [AxiAddrWidth-1:0] page_end;
   logic [AxiAddrWidth-1:0] max_end;
   logic [AxiAddrWidth-1:0] span;
   logic [BeatBits-1:0]     last_off;
   logic [LbnWidth-1:0]     last_cnt;

   // burst ends at the earliest of request end, 4 KiB page end, max burst length
   always_comb begin
      aligned   = {cur_addr[AxiAddrWidth-1:BeatBits], BeatBits'(0)};
      page_end  = {cur_addr[AxiAddrWidth-1:PageBits] + (AxiAddrWidth-PageBits)'(1),
                   PageBits'(0)};
      max_end   = aligned + AxiAddrWidth'(MaxBurstBeats * BusBytes);
      burst_end = end_addr;
      if (page_end < burst_end) burst_end = page_end;
      if (max_end < burst_end)  burst_end = max_end;
      span      = burst_end - aligned + AxiAddrWidth'(BusBytes - 1);
      beats     = BeatCntWidth'(span >> BeatBits);
      // offset of the last byte within its beat; wraps to BusBytes-1 when aligned
      last_off  = burst_end[BeatBits-1:0] - BeatBits'(1);
      last_cnt  = LbnWidth'(last_off) + LbnWidth'(1);
      lb_n      = last_cnt << 1;
      is_final  = (burst_end == end_addr);
   end

endmodule

// File: rtl/seq_store_txn_ctrl.sv
// Sequences one unit-stride vector store into AXI INCR write bursts, emits a
// global meta record and per-beat control to the store datapath, tracks
// outstanding B responses and reports completion.
// Ports: req_* (request in), meta_glb_* (meta out), txn_ctrl_* (beat control
// out), axi_aw_* (AW out), axi_b_* (B in), done_* (completion out).
// Optional: SEQ_STORE_TXN_PERF_EN adds perf_aw_stall_o, perf_txn_stall_o,
// perf_bursts_o saturating counters.
module seq_store_txn_ctrl
   import vlsu_pkg::*;
   import axi_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  store_req_t          req_i,
   output logic                meta_glb_valid_o,
   input  logic                meta_glb_ready_i,
   output meta_glb_t           meta_glb_o,
   output logic                txn_ctrl_valid_o,
   input  logic                txn_ctrl_ready_i,
   output seq_store_txn_ctrl_t txn_ctrl_o,
   output logic                axi_aw_valid_o,
   input  logic                axi_aw_ready_i,
   output aw_chan_t            axi_aw_o,
   input  logic                axi_b_valid_i,
   output logic                axi_b_ready_o,
   input  logic [1:0]          axi_b_resp_i,
   output logic                done_valid_o,
   input  logic                done_ready_i,
   output logic                done_err_o
`ifdef SEQ_STORE_TXN_PERF_EN
   ,
   output logic [31:0]         perf_aw_stall_o,
   output logic [31:0]         perf_txn_stall_o,
   output logic [31:0]         perf_bursts_o
`endif
);

   localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_META, S_BURST, S_BEATS, S_WAIT_B, S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic                    ready_en_q;
   logic [AxiAddrWidth-1:0] cur_addr_q, cur_addr_d;
   logic [AxiAddrWidth-1:0] end_addr_q, end_addr_d;
   logic [VlWidth-1:0]      vstart_q, vstart_d;
   logic [1:0]              sew_q, sew_d;
   logic [AxiAddrWidth-1:0] burst_addr_q, burst_addr_d;
   logic [AxiAddrWidth-1:0] burst_end_q, burst_end_d;
   logic [7:0]              rmn_q, rmn_d;
   logic [LbnWidth-1:0]     lb_n_q, lb_n_d;
   logic                    final_q, final_d;
   logic                    head_q, head_d;
   logic [OutW-1:0]         out_q, out_d;
   logic                    err_q, err_d;

   logic [AxiAddrWidth-1:0] req_start;
   logic [AxiAddrWidth-1:0] req_bytes;
   logic [AxiAddrWidth-1:0] calc_end;
   logic [BeatCntWidth-1:0] calc_beats;
   logic [LbnWidth-1:0]     calc_lb_n;
   logic                    calc_final;
   logic                    req_fire, meta_fire, aw_fire, txn_fire, b_fire, done_fire;

   seq_store_burst_calc u_burst_calc (
      .cur_addr  (cur_addr_q),
      .end_addr  (end_addr_q),
      .burst_end (calc_end),
      .beats     (calc_beats),
      .lb_n      (calc_lb_n),
      .is_final  (calc_final)
   );

   // request decode at address width
   assign req_start = req_i.addr + (AxiAddrWidth'(req_i.vstart) << req_i.sew);
   assign req_bytes = (AxiAddrWidth'(req_i.vl) - AxiAddrWidth'(req_i.vstart)) << req_i.sew;

   // channel payloads come only from registers so they hold while stalled
   assign meta_glb_o.vstart   = vstart_q;
   assign meta_glb_o.sew      = sew_q;
   assign axi_aw_o.addr       = cur_addr_q;
   assign axi_aw_o.len        = 8'(calc_beats - BeatCntWidth'(1));
   assign axi_aw_o.size       = 3'(BeatBits);
   assign axi_aw_o.burst      = BurstIncr;
   assign txn_ctrl_o.addr         = burst_addr_q;
   assign txn_ctrl_o.is_head      = head_q;
   assign txn_ctrl_o.rmn_beat     = rmn_q;
   assign txn_ctrl_o.lb_n         = (rmn_q == 8'd0) ? lb_n_q : '0;
   assign txn_ctrl_o.is_final_txn = final_q;

   // next-state, handshakes and channel valids
   always_comb begin
      state_d          = state_q;
      cur_addr_d       = cur_addr_q;
      end_addr_d       = end_addr_q;
      vstart_d         = vstart_q;
      sew_d            = sew_q;
      burst_addr_d     = burst_addr_q;
      burst_end_d      = burst_end_q;
      rmn_d            = rmn_q;
      lb_n_d           = lb_n_q;
      final_d          = final_q;
      head_d           = head_q;
      out_d            = out_q;
      err_d            = err_q;
      req_ready_o      = ready_en_q && (state_q == S_IDLE);
      meta_glb_valid_o = (state_q == S_META);
      axi_aw_valid_o   = (state_q == S_BURST) && (out_q < OutW'(MaxOutstanding));
      txn_ctrl_valid_o = (state_q == S_BEATS);
      done_valid_o     = (state_q == S_DONE);
      done_err_o       = err_q && (state_q == S_DONE);
      axi_b_ready_o    = (out_q != '0);

      req_fire  = req_valid_i && req_ready_o;
      meta_fire = meta_glb_valid_o && meta_glb_ready_i;
      aw_fire   = axi_aw_valid_o && axi_aw_ready_i;
      txn_fire  = txn_ctrl_valid_o && txn_ctrl_ready_i;
      b_fire    = axi_b_valid_i && axi_b_ready_o;
      done_fire = done_valid_o && done_ready_i;

      case (state_q)
         S_IDLE: begin
            if (req_fire) begin
               cur_addr_d = req_start;
               end_addr_d = req_start + req_bytes;
               vstart_d   = req_i.vstart;
               sew_d      = req_i.sew;
               state_d    = (req_bytes == '0) ? S_DONE : S_META;
            end
         end
         S_META: begin
            if (meta_fire) state_d = S_BURST;
         end
         S_BURST: begin
            if (aw_fire) begin
               burst_addr_d = cur_addr_q;
               burst_end_d  = calc_end;
               rmn_d        = 8'(calc_beats - BeatCntWidth'(1));
               lb_n_d       = calc_lb_n;
               final_d      = calc_final;
               head_d       = 1'b1;
               state_d      = S_BEATS;
            end
         end
         S_BEATS: begin
            if (txn_fire) begin
               head_d = 1'b0;
               if (rmn_q == 8'd0) begin
                  if (final_q) begin
                     state_d = S_WAIT_B;
                  end else begin
                     cur_addr_d = burst_end_q;
                     state_d    = S_BURST;
                  end
               end else begin
                  rmn_d = rmn_q - 8'd1;
               end
            end
         end
         S_WAIT_B: begin
            if (out_q == '0) state_d = S_DONE;
         end
         S_DONE: begin
            if (done_fire) begin
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // simultaneous AW and B leaves the count unchanged
      if (aw_fire && !b_fire)      out_d = out_q + OutW'(1);
      else if (b_fire && !aw_fire) out_d = out_q - OutW'(1);

      if (b_fire && (axi_b_resp_i != RespOkay)) err_d = 1'b1;
   end

   // state and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         ready_en_q   <= 1'b0;
         cur_addr_q   <= '0;
         end_addr_q   <= '0;
         vstart_q     <= '0;
         sew_q        <= '0;
         burst_addr_q <= '0;
         burst_end_q  <= '0;
         rmn_q        <= '0;
         lb_n_q       <= '0;
         final_q      <= 1'b0;
         head_q       <= 1'b0;
         out_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ready_en_q   <= 1'b1;
         cur_addr_q   <= cur_addr_d;
         end_addr_q   <= end_addr_d;
         vstart_q     <= vstart_d;
         sew_q        <= sew_d;
         burst_addr_q <= burst_addr_d;
         burst_end_q  <= burst_end_d;
         rmn_q        <= rmn_d;
         lb_n_q       <= lb_n_d;
         final_q      <= final_d;
         head_q       <= head_d;
         out_q        <= out_d;
         err_q        <= err_d;
      end
   end

`ifdef SEQ_STORE_TXN_PERF_EN
   // saturating stall and burst counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_aw_stall_o  <= '0;
         perf_txn_stall_o <= '0;
         perf_bursts_o    <= '0;
      end else begin
         if (axi_aw_valid_o && !axi_aw_ready_i && (perf_aw_stall_o != '1))
            perf_aw_stall_o <= perf_aw_stall_o + 32'd1;
         if (txn_ctrl_valid_o && !txn_ctrl_ready_i && (perf_txn_stall_o != '1))
            perf_txn_stall_o <= perf_txn_stall_o + 32'd1;
         if (aw_fire && (perf_bursts_o != '1))
            perf_bursts_o <= perf_bursts_o + 32'd1;
      end
   end
`endif

   // a B response must always belong to an issued AW
   a_no_b_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (axi_b_valid_i && axi_b_ready_o) |-> (out_q != '0));
   a_out_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
      out_q <= OutW'(MaxOutstanding));

endmodule
